// File: rtl/muldiv_seq_unit.sv
// rtl/muldiv_seq_unit.sv - iterative RV32M multiply/divide unit beside the ALU, stalls EX until Result is ready
// MULDIV_FAST_MUL_EN: multiplies finish in a single cycle; divides stay iterative.

module muldiv_seq_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            ALUOp,
  input  logic [6:0]            Funct7,
  input  logic [2:0]            Funct3,
  input  logic                  Start,
  input  logic                  Flush,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  IsMulDiv,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Stall,
  output logic [DATA_WIDTH-1:0] Result
);
  localparam int W = DATA_WIDTH;
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [2:0]           op;
  logic                 sa, sb;
  logic [W-1:0]         opnd, hi, lo;

  function automatic logic [W-1:0] mul_pick(input logic [2*W-1:0] p, input logic [1:0] sel,
                                            input logic neg);
    logic [2*W-1:0] s;
    s = neg ? -p : p;
    return (sel == 2'b00) ? s[W-1:0] : s[2*W-1:W];
  endfunction

  logic         a_signed, b_signed, sa_in, sb_in, is_div, div_zero, div_ovf;
  logic [W-1:0] ma_in, mb_in, special_res;

  // Operands are reduced to magnitudes at accept; the sign is reapplied on the final cycle.
  always_comb begin
    is_div      = Funct3[2];
    a_signed    = (Funct3 == 3'b001) || (Funct3 == 3'b010) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    b_signed    = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    sa_in       = a_signed & SrcA[W-1];
    sb_in       = b_signed & SrcB[W-1];
    ma_in       = sa_in ? -SrcA : SrcA;
    mb_in       = sb_in ? -SrcB : SrcB;
    div_zero    = is_div && (SrcB == '0);
    div_ovf     = is_div && !Funct3[0] && (SrcA == MIN_NEG) && (SrcB == '1);
    special_res = div_zero ? (Funct3[1] ? SrcA : '1) : (Funct3[1] ? '0 : SrcA);
  end

  logic [W:0]   mul_sum, div_shift, div_diff;
  logic         div_ok;
  logic [W-1:0] nxt_hi, nxt_lo, calc_res;

  // hi/lo are shared: product {hi,lo} for multiply, remainder/quotient for divide.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_shift = {hi, lo[W-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ok    = ~div_diff[W];
    if (op[2]) begin
      nxt_hi   = div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
      nxt_lo   = {lo[W-2:0], div_ok};
      calc_res = op[1] ? (sa ? -nxt_hi : nxt_hi) : ((sa ^ sb) ? -nxt_lo : nxt_lo);
    end else begin
      nxt_hi   = mul_sum[W:1];
      nxt_lo   = {mul_sum[0], lo[W-1:1]};
      calc_res = mul_pick({nxt_hi, nxt_lo}, op[1:0], sa ^ sb);
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_prod;
  logic [W-1:0]   fast_res;

  always_comb begin
    fast_prod = {{W{1'b0}}, ma_in} * {{W{1'b0}}, mb_in};
    fast_res  = mul_pick(fast_prod, Funct3[1:0], sa_in ^ sb_in);
  end
`endif

  assign IsMulDiv = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
  assign Busy     = (state != IDLE);
  assign Stall    = Start & IsMulDiv & ~Done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      opnd   <= '0;
      hi     <= '0;
      lo     <= '0;
      Result <= '0;
      Done   <= 1'b0;
    end else if (Flush) begin
      state <= IDLE;
      cnt   <= '0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start && IsMulDiv) begin
            op   <= Funct3;
            sa   <= sa_in;
            sb   <= sb_in;
            hi   <= '0;
            lo   <= is_div ? ma_in : mb_in;
            opnd <= is_div ? mb_in : ma_in;
            if (div_zero || div_ovf) begin
              Result <= special_res;
              Done   <= 1'b1;
              state  <= DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!is_div) begin
              Result <= fast_res;
              Done   <= 1'b1;
              state  <= DONE;
            end
`endif
            else begin
              cnt   <= CNT_WIDTH'(W);
              state <= CALC;
            end
          end
        end
        CALC: begin
          hi  <= nxt_hi;
          lo  <= nxt_lo;
          cnt <= cnt - CNT_WIDTH'(1);
          if (cnt == CNT_WIDTH'(1)) begin
            Result <= calc_res;
            Done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// tb/tb_muldiv_seq_unit.sv - scoreboard bench for muldiv_seq_unit at DATA_WIDTH=32

module tb_muldiv_seq_unit;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ALUOp;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic        Start, Flush;
  logic [31:0] SrcA, SrcB;
  logic        IsMulDiv, Busy, Done, Stall;
  logic [31:0] Result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_res_q[$];
  int          exp_lat_q[$];
  logic [31:0] last_res;

  always #5 clk = ~clk;

  muldiv_seq_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
    .Start(Start), .Flush(Flush), .SrcA(SrcA), .SrcB(SrcB), .IsMulDiv(IsMulDiv),
    .Busy(Busy), .Done(Done), .Stall(Stall), .Result(Result)
  );

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int          ai, bi;
    longint      p;
    logic [63:0] pu;
    logic [31:0] r;
    ai = a;
    bi = b;
    r  = '0;
    case (f3)
      3'd0: r = a * b;
      3'd1: begin p = longint'(ai) * longint'(bi); r = p[63:32]; end
      3'd2: begin p = longint'(ai) * longint'({32'b0, b}); r = p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ((a == MIN_NEG && b == 32'hFFFF_FFFF) ? a : 32'(ai / bi));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ((a == MIN_NEG && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ai % bi));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 0 || (!f3[0] && a == MIN_NEG && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  // Called on a falling edge with the unit idle; returns on a falling edge with it idle again.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int exp_l, input string name);
    int          cyc;
    bit          stall_bad;
    logic        stall_done;
    logic [31:0] got, r;
    int          l;
    exp_res_q.push_back(exp_r);
    exp_lat_q.push_back(exp_l);
    ALUOp = 2'b10; Funct7 = 7'd1; Funct3 = f3; SrcA = a; SrcB = b; Start = 1'b1; Flush = 1'b0;
    #1;
    checks++;
    if (Stall !== 1'b1) begin errors++; $display("FAIL %s stall_at_accept: got %b expected 1", name, Stall); end
    @(posedge clk);
    cyc = 0;
    stall_bad = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (Done !== 1'b1 && Stall !== 1'b1) stall_bad = 1'b1;
      if (cyc == 2 && Done !== 1'b1) begin SrcA = $urandom; SrcB = $urandom; end
    end while (Done !== 1'b1 && cyc < 100);
    stall_done = Stall;
    got = Result;
    Start = 1'b0;
    r = exp_res_q.pop_front();
    l = exp_lat_q.pop_front();
    checks++;
    if (Done !== 1'b1 || cyc != l) begin
      errors++; $display("FAIL %s latency: got cycle %0d (done=%b) expected cycle %0d", name, cyc, Done, l);
    end
    checks++;
    if (got !== r) begin errors++; $display("FAIL %s result: got %h expected %h", name, got, r); end
    checks++;
    if (stall_done !== 1'b0) begin errors++; $display("FAIL %s stall_at_done: got %b expected 0", name, stall_done); end
    checks++;
    if (stall_bad) begin errors++; $display("FAIL %s stall_hold: got low before done expected high", name); end
    last_res = r;
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL %s idle_after: got busy=%b done=%b expected 0 0", name, Busy, Done);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; Start = 1'b0; Flush = 1'b0; ALUOp = 2'b00; Funct7 = 7'd0; Funct3 = 3'd0;
    SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (Result !== 32'd0 || Done !== 1'b0 || Busy !== 1'b0 || Stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got result=%h done=%b busy=%b stall=%b expected 0 0 0 0", Result, Done, Busy, Stall);
    end
    reset = 1'b0;
    last_res = '0;
    @(negedge clk);
  endtask

  task automatic test_mul;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_7xm3");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu_max");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, "mulh_m1");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT, "mulhsu_m1x2");
    run_op(3'd0, 32'd6, 32'd7, 32'd42, MUL_LAT, "mul_6x7");
  endtask

  task automatic test_div;
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
  endtask

  task automatic test_special;
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
    run_op(3'd6, 32'd5, 32'd0, 32'd5, 1, "rem_by0");
    run_op(3'd4, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG, 1, "div_ovf");
  endtask

  task automatic test_flush;
    logic [31:0] prev;
    bit          saw_done;
    prev = last_res;
    saw_done = 1'b0;
    ALUOp = 2'b10; Funct7 = 7'd1; Funct3 = 3'd4; SrcA = 32'd100; SrcB = 32'd7; Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (Done === 1'b1) saw_done = 1'b1;
    end
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || saw_done) begin
      errors++; $display("FAIL flush_kill: got busy=%b done=%b early_done=%b expected 0 0 0", Busy, Done, saw_done);
    end
    checks++;
    if (Result !== prev) begin errors++; $display("FAIL flush_result_kept: got %h expected %h", Result, prev); end
    run_op(3'd0, 32'd7, 32'd3, 32'd21, MUL_LAT, "mul_after_flush");
    Funct3 = 3'd0; SrcA = 32'd9; SrcB = 32'd9; Start = 1'b1; Flush = 1'b1;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    checks++;
    if (Busy !== 1'b0 || Result !== 32'd21) begin
      errors++; $display("FAIL flush_start_idle: got busy=%b result=%h expected 0 00000015", Busy, Result);
    end
  endtask

  task automatic test_random;
    logic [2:0]  f3;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (i == 5) begin f3 = 3'd6; a = MIN_NEG; b = 32'hFFFF_FFFF; end
      if (i == 9) begin f3 = 3'd1; a = MIN_NEG; b = MIN_NEG; end
      run_op(f3, a, b, ref_model(f3, a, b), ref_lat(f3, a, b), "rand");
    end
  endtask

  task automatic test_not_muldiv;
    ALUOp = 2'b10; Funct7 = 7'd0; Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd4; Start = 1'b1;
    #1;
    checks++;
    if (Stall !== 1'b0 || IsMulDiv !== 1'b0) begin
      errors++; $display("FAIL not_md_stall: got stall=%b ismd=%b expected 0 0", Stall, IsMulDiv);
    end
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL not_md_busy: got %b expected 0", Busy); end
    ALUOp = 2'b00; Funct7 = 7'd1;
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || Stall !== 1'b0) begin
      errors++; $display("FAIL not_rtype_busy: got busy=%b stall=%b expected 0 0", Busy, Stall);
    end
    Start = 1'b0;
  endtask

  task automatic test_reset_midop;
    ALUOp = 2'b10; Funct7 = 7'd1; Funct3 = 3'd5; SrcA = 32'd1000; SrcB = 32'd3; Start = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL midop_busy: got %b expected 1", Busy); end
    Start = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (Result !== 32'd0 || Done !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL midop_reset: got result=%h done=%b busy=%b expected 0 0 0", Result, Done, Busy);
    end
    @(negedge clk);
    reset = 1'b0;
    last_res = '0;
    @(negedge clk);
    run_op(3'd7, 32'd1000, 32'd3, 32'd1, 33, "remu_after_reset");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_random();
    test_not_muldiv();
    test_reset_midop();
    checks++;
    if (exp_res_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_res_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
